cp0_regfile: RTL and testbench

- Coprocessor-0 register file; the stage directly downstream of the exception decision logic.
- Consumes the committed exception flag, type, bad address, PC and delay-slot bit, and updates BadVAddr, Count, Compare, Status, Cause and EPC.
- Produces EPC and the interrupt request back to the exception logic, plus MFC0 read data to the pipeline.
- MTC0 writes arrive from the MEM stage.

---
 rtl/cp0_regfile.sv | 220 ++++++++++++++++++++++
 tb/tb_cp0_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Sits downstream of the exception decision logic and applies committed
// exceptions/ERET, MTC0 writes, the Count/Compare timer and external
// interrupt sampling. Returns EPC, Status, Cause and the interrupt request.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   cp0_raddr_i / cp0_rdata_o   MFC0 register number / read data (comb)
//   cp0_we_i, cp0_waddr_i,
//   cp0_wdata_i                 MTC0 write port from MEM
//   exc_flag_i, exc_type_i,
//   exc_pc_i, exc_bd_i,
//   exc_baddr_i                 committed exception / ERET information
//   ext_int_i                   level-sensitive hardware interrupt lines
//   epc_o, status_o, cause_o    current register values
//   intr_o                      pending enabled interrupt (comb from regs)
module cp0_regfile #(
  parameter int unsigned EXCT_W    = 4,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [4:0]        cp0_raddr_i,
  output logic [31:0]       cp0_rdata_o,
  input  logic              cp0_we_i,
  input  logic [4:0]        cp0_waddr_i,
  input  logic [31:0]       cp0_wdata_i,
  input  logic              exc_flag_i,
  input  logic [EXCT_W-1:0] exc_type_i,
  input  logic [31:0]       exc_pc_i,
  input  logic              exc_bd_i,
  input  logic [31:0]       exc_baddr_i,
  input  logic [5:0]        ext_int_i,
  output logic [31:0]       epc_o,
  output logic [31:0]       status_o,
  output logic [31:0]       cause_o,
  output logic              intr_o
);

  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [DATA_W-1:0] TYPE_INTR   = 32'd1;
  localparam logic [DATA_W-1:0] TYPE_ADEL_F = 32'd2;
  localparam logic [DATA_W-1:0] TYPE_ADEL_D = 32'd3;
  localparam logic [DATA_W-1:0] TYPE_ADES   = 32'd4;
  localparam logic [DATA_W-1:0] TYPE_OV     = 32'd5;
  localparam logic [DATA_W-1:0] TYPE_SYS    = 32'd6;
  localparam logic [DATA_W-1:0] TYPE_BP     = 32'd7;
  localparam logic [DATA_W-1:0] TYPE_RI     = 32'd8;
  localparam logic [DATA_W-1:0] TYPE_ERET   = 32'd9;

  // State registers
  logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
  logic [DATA_W-1:0] count_q,    count_d;
  logic [DATA_W-1:0] compare_q,  compare_d;
  logic [DATA_W-1:0] epc_q,      epc_d;
  logic [7:0]        im_q,       im_d;
  logic              exl_q,      exl_d;
  logic              ie_q,       ie_d;
  logic              bd_q,       bd_d;
  logic              ti_q,       ti_d;
  logic [4:0]        exccode_q,  exccode_d;
  logic [1:0]        ip_sw_q,    ip_sw_d;
  logic [5:0]        ext_q,      ext_d;
  logic              phase_q,    phase_d;

  logic [DATA_W-1:0] exc_type_w;
  logic              is_exc;
  logic              is_eret;
  logic              is_addr_exc;
  logic              tick;
  logic              ti_hit;
  logic [4:0]        exc_code;
  logic [DATA_W-1:0] status_w;
  logic [DATA_W-1:0] cause_w;

  // Zero-extend the type so decoding is independent of EXCT_W
  assign exc_type_w = DATA_W'(exc_type_i);

  // Commit decode; types 0 and 10..15 are no-ops
  always_comb begin
    is_exc      = exc_flag_i && (exc_type_w >= TYPE_INTR) && (exc_type_w <= TYPE_RI);
    is_eret     = exc_flag_i && (exc_type_w == TYPE_ERET);
    is_addr_exc = (exc_type_w >= TYPE_ADEL_F) && (exc_type_w <= TYPE_ADES);
  end

  // Type to Cause.ExcCode
  always_comb begin
    exc_code = 5'h00;
    case (exc_type_w)
      TYPE_INTR:   exc_code = 5'h00;
      TYPE_ADEL_F: exc_code = 5'h04;
      TYPE_ADEL_D: exc_code = 5'h04;
      TYPE_ADES:   exc_code = 5'h05;
      TYPE_OV:     exc_code = 5'h0C;
      TYPE_SYS:    exc_code = 5'h08;
      TYPE_BP:     exc_code = 5'h09;
      TYPE_RI:     exc_code = 5'h0A;
      default:     exc_code = 5'h00;
    endcase
  end

  // Count advances on every clock (div 1) or when the phase bit is set (div 2)
  assign tick   = (COUNT_DIV == 1) ? 1'b1 : phase_q;
  assign ti_hit = tick && (count_q == compare_q);

  // Next-state logic; an exception/ERET commit swallows a same-cycle MTC0
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q + DATA_W'(tick);
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q | ti_hit;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    ext_d      = ext_int_i;
    phase_d    = ~phase_q;

    if (is_exc) begin
      // Nested exceptions keep the original return point
      if (!exl_q) begin
        epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exl_d     = 1'b1;
      exccode_d = exc_code;
      if (is_addr_exc) begin
        badvaddr_d = exc_baddr_i;
      end
    end else if (is_eret) begin
      exl_d = 1'b0;
    end else if (cp0_we_i) begin
      case (cp0_waddr_i)
        REG_COUNT:   count_d = cp0_wdata_i;
        REG_COMPARE: begin
          compare_d = cp0_wdata_i;
          ti_d      = 1'b0;  // clear beats a same-cycle timer hit
        end
        REG_STATUS: begin
          im_d  = cp0_wdata_i[15:8];
          exl_d = cp0_wdata_i[1];
          ie_d  = cp0_wdata_i[0];
        end
        REG_CAUSE:   ip_sw_d = cp0_wdata_i[9:8];
        REG_EPC:     epc_d   = cp0_wdata_i;
        default:     ;
      endcase
    end
  end

  // State update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ext_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ext_q      <= ext_d;
      phase_q    <= phase_d;
    end
  end

  // Architectural views; BEV (bit 22) is hard-wired to 1
  assign status_w = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  // IP[7] merges the timer with the sixth hardware line
  assign cause_w  = {bd_q, ti_q, 14'd0, ti_q | ext_q[5], ext_q[4:0], ip_sw_q,
                     1'b0, exccode_q, 2'd0};

  assign epc_o    = epc_q;
  assign status_o = status_w;
  assign cause_o  = cause_w;
  assign intr_o   = ie_q & ~exl_q & (|(cause_w[15:8] & im_q));

  // MFC0 read mux
  always_comb begin
    cp0_rdata_o = '0;
    case (cp0_raddr_i)
      REG_BADVADDR: cp0_rdata_o = badvaddr_q;
      REG_COUNT:    cp0_rdata_o = count_q;
      REG_COMPARE:  cp0_rdata_o = compare_q;
      REG_STATUS:   cp0_rdata_o = status_w;
      REG_CAUSE:    cp0_rdata_o = cause_w;
      REG_EPC:      cp0_rdata_o = epc_q;
      default:      cp0_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a word-level CP0 model.
module tb_cp0_regfile;

  localparam int unsigned TB_DIV = 2;

  logic        clk;
  logic        resetn;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        flag;
  logic [3:0]  etype;
  logic [31:0] pc;
  logic        bd;
  logic [31:0] baddr;
  logic [5:0]  ext;
  logic [31:0] epc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic        intr_o;

  cp0_regfile #(.EXCT_W(4), .COUNT_DIV(TB_DIV)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cp0_raddr_i (raddr),
    .cp0_rdata_o (rdata),
    .cp0_we_i    (we),
    .cp0_waddr_i (waddr),
    .cp0_wdata_i (wdata),
    .exc_flag_i  (flag),
    .exc_type_i  (etype),
    .exc_pc_i    (pc),
    .exc_bd_i    (bd),
    .exc_baddr_i (baddr),
    .ext_int_i   (ext),
    .epc_o       (epc_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .intr_o      (intr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  // Reference model: whole architectural words
  logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_ti;
  int unsigned m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
    m_cause = 0; m_epc = 0; m_ti = 0; m_cyc = 0;
  endtask

  function automatic logic [4:0] code_of(input int t);
    case (t)
      1: return 5'h00;
      2, 3: return 5'h04;
      4: return 5'h05;
      5: return 5'h0C;
      6: return 5'h08;
      7: return 5'h09;
      8: return 5'h0A;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_intr();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h00);
  endfunction

  // One clock edge of the architecture, from the inputs held before the edge
  task automatic model_step();
    int  t;
    bit  exc, eret, wr, tick, hit, exl_old;
    t       = int'(etype);
    exc     = flag && t >= 1 && t <= 8;
    eret    = flag && t == 9;
    wr      = we && !exc && !eret;
    tick    = (TB_DIV == 1) || (m_cyc % 2 == 1);
    m_cyc++;
    hit     = tick && (m_count == m_compare);
    exl_old = m_status[1];
    if (wr && waddr == 5'd9) m_count = wdata;
    else                     m_count = m_count + (tick ? 32'd1 : 32'd0);
    if (hit) m_ti = 1;
    if (exc) begin
      if (!exl_old) begin
        m_epc       = bd ? pc - 32'd4 : pc;
        m_cause[31] = bd;
      end
      m_status[1]  = 1'b1;
      m_cause[6:2] = code_of(t);
      if (t >= 2 && t <= 4) m_badv = baddr;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (waddr)
        5'd11: begin m_compare = wdata; m_ti = 0; end
        5'd12: m_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
        5'd13: m_cause[9:8] = wdata[9:8];
        5'd14: m_epc = wdata;
        default: ;
      endcase
    end
    m_cause[14:10] = ext[4:0];
    m_cause[30]    = m_ti;
    m_cause[15]    = m_ti | ext[5];
  endtask

  always @(posedge clk) if (resetn) model_step();

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("rdata", rdata, m_read(raddr));
      chk("epc_o", epc_o, m_epc);
      chk("status_o", status_o, m_status);
      chk("cause_o", cause_o, m_cause);
      chk("intr_o", 32'(intr_o), 32'(m_intr()));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic clr_in();
    we = 0; flag = 0; bd = 0; etype = 0;
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 8))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_in();
    we    = ($urandom_range(0, 2) == 0);
    waddr = pick_addr();
    wdata = $urandom;
    if ((waddr == 5'd9 || waddr == 5'd11) && $urandom_range(0, 1) == 1)
      wdata = 32'($urandom_range(0, 40));
    flag  = ($urandom_range(0, 5) == 0);
    etype = 4'($urandom_range(0, 15));
    pc    = $urandom;
    bd    = 1'($urandom_range(0, 1));
    baddr = $urandom;
    if ($urandom_range(0, 7) == 0) ext = 6'($urandom);
    raddr = pick_addr();
  endtask

  initial begin : main
    logic got_ti;
    resetn = 0; raddr = 0; we = 0; waddr = 0; wdata = 0; flag = 0; etype = 0;
    pc = 0; bd = 0; baddr = 0; ext = 0;
    model_reset();
    repeat (3) step();
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    resetn = 1; model_reset(); check_en = 1;
    rd_chk("rd_status", 5'd12, 32'h0040_0000);
    rd_chk("rd_cause", 5'd13, 32'h0);
    chk("rst_intr", 32'(intr_o), 32'h0);
    repeat (10) step();
    rd_chk("count_10clk", 5'd9, 32'd5);

    // Status IM[2]/IE then a hardware line
    we = 1; waddr = 5'd12; wdata = 32'h0000_0401; step(); we = 0;
    ext = 6'b000001; step();
    chk("cause_ip2", 32'(cause_o[10]), 32'h1);
    chk("intr_ip2", 32'(intr_o), 32'h1);
    we = 1; wdata = 32'h0000_0403; step(); we = 0;
    chk("intr_exl", 32'(intr_o), 32'h0);
    we = 1; wdata = 32'h0; step(); we = 0; ext = 0; step();

    // AdEL-data in a delay slot, then a nested overflow
    flag = 1; etype = 4'd3; pc = 32'hBFC0_0100; bd = 1; baddr = 32'h3; step(); clr_in();
    chk("exc_epc", epc_o, 32'hBFC0_00FC);
    chk("exc_bd", 32'(cause_o[31]), 32'h1);
    chk("exc_code", 32'(cause_o[6:2]), 32'h04);
    chk("exc_exl", 32'(status_o[1]), 32'h1);
    rd_chk("exc_badv", 5'd8, 32'h3);
    flag = 1; etype = 4'd5; pc = 32'h0000_0100; baddr = 32'h55; step(); clr_in();
    chk("nest_epc", epc_o, 32'hBFC0_00FC);
    chk("nest_code", 32'(cause_o[6:2]), 32'h0C);
    rd_chk("nest_badv", 5'd8, 32'h3);

    // ERET
    flag = 1; etype = 4'd9; step(); clr_in();
    chk("eret_exl", 32'(status_o[1]), 32'h0);
    chk("eret_epc", epc_o, 32'hBFC0_00FC);
    chk("eret_code", 32'(cause_o[6:2]), 32'h0C);

    // Timer
    we = 1; waddr = 5'd11; wdata = 32'd20; step();
    chk("ti_clr0", 32'(cause_o[30]), 32'h0);
    waddr = 5'd9; wdata = 32'd10; step();
    waddr = 5'd12; wdata = 32'h0000_8001; step(); we = 0;
    got_ti = 0;
    for (int i = 0; i < 60; i++) begin
      if (cause_o[30]) begin got_ti = 1; break; end
      step();
    end
    chk("ti_set", 32'(got_ti), 32'h1);
    rd_chk("ti_count", 5'd9, 32'd21);
    chk("ti_intr", 32'(intr_o), 32'h1);
    we = 1; waddr = 5'd11; wdata = 32'h1000; step(); we = 0;
    chk("ti_clr", 32'(cause_o[30]), 32'h0);
    chk("ti_ip7", 32'(cause_o[15]), 32'h0);
    chk("ti_intr0", 32'(intr_o), 32'h0);

    // Exception beats same-cycle MTC0 EPC
    we = 1; waddr = 5'd14; wdata = 32'h1234;
    flag = 1; etype = 4'd6; pc = 32'h8000_0000; bd = 0; step(); clr_in();
    chk("prio_epc", epc_o, 32'h8000_0000);
    chk("prio_code", 32'(cause_o[6:2]), 32'h08);
    flag = 1; etype = 4'd9; step(); clr_in();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
    end

    // Asynchronous reset mid-operation
    check_en = 0; resetn = 0;
    #1;
    chk("mid_status", status_o, 32'h0040_0000);
    chk("mid_cause", cause_o, 32'h0);
    chk("mid_epc", epc_o, 32'h0);
    rd_chk("mid_count", 5'd9, 32'h0);
    model_reset();
    step(); step();
    resetn = 1; model_reset(); check_en = 1;
    for (int i = 0; i < 500; i++) begin
      rand_in();
      step();
    end
    clr_in();
    step();
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
